// File: rtl/jk_drive_pkg.sv
// -----------------------------------------------------------------------------
// jk_drive_pkg
// Shared definitions for the JK drive sequencer:
//   - state_e      : sequencer FSM states (IDLE, DRIVE, CHECK)
//   - MODE_*       : target mode encodings (TOGGLE uses Q feedback, FORCE
//                    uses set/reset and ignores Q)
//   - HOLD/RESET/SET/TOGGLE : {J,K} excitation pairs for one flip-flop
//   - cnt_width()  : width of the retry counter for a given retry budget
// -----------------------------------------------------------------------------
package jk_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_FORCE  = 1'b1;

  // {J,K} pairs as seen by a standard JK flip-flop
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  // A retry budget of zero still needs a 1-bit counter port.
  function automatic int cnt_width(input int max_retry);
    if (max_retry < 1) begin
      return 1;
    end
    return $clog2(max_retry + 1);
  endfunction

endpackage : jk_drive_pkg

// File: rtl/jk_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
// Per-bit combinational excitation map: given the flip-flop's present Q, the
// desired Q and the drive mode, produce the J/K pair that moves Q to target
// at the next clock edge.
//
// Ports:
//   i_q      in  1 : present Q of the flip-flop
//   i_tgt    in  1 : desired Q
//   i_mode   in  1 : MODE_TOGGLE or MODE_FORCE
//   o_j      out 1 : J excitation
//   o_k      out 1 : K excitation
// -----------------------------------------------------------------------------
module jk_excite
  import jk_drive_pkg::*;
(
  input  logic i_q,
  input  logic i_tgt,
  input  logic i_mode,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  always_comb begin
    w_jk = HOLD;
    if (i_mode == MODE_FORCE) begin
      // Set/reset drive does not depend on the present Q at all.
      w_jk = i_tgt ? SET : RESET;
    end else begin
      // Feedback drive: only bits that are wrong are toggled.
      w_jk = (i_q == i_tgt) ? HOLD : TOGGLE;
    end
  end

  assign o_j = w_jk[1];
  assign o_k = w_jk[0];

endmodule : jk_excite

// File: rtl/jk_drive_sequencer.sv
// -----------------------------------------------------------------------------
// jk_drive_sequencer
// Drives the J/K inputs of an external bank of WIDTH JK flip-flops so that the
// bank's Q word reaches a requested target. After each one-cycle drive the
// bank's Q is read back and compared; on mismatch the drive is repeated up to
// MAX_RETRY more times before reporting an error.
//
// Ports:
//   clk        in  1      : clock, shared with the JK bank
//   rst_n      in  1      : asynchronous active-low reset
//   tgt_valid  in  1      : a target word is offered
//   tgt_data   in  WIDTH  : target Q word
//   tgt_mode   in  1      : 0 = TOGGLE (feedback), 1 = FORCE (set/reset)
//   tgt_ready  out 1      : high in IDLE, target may be accepted
//   q_fb       in  WIDTH  : Q outputs of the JK bank (no added delay)
//   j          out WIDTH  : J drive to the bank (non-zero only in DRIVE)
//   k          out WIDTH  : K drive to the bank (non-zero only in DRIVE)
//   busy       out 1      : high in DRIVE and CHECK
//   done       out 1      : one-cycle pulse after a successful check
//   err        out 1      : one-cycle pulse after retries are exhausted
//   retry_cnt  out CNT_W  : re-drives used by current/last transaction
// -----------------------------------------------------------------------------
module jk_drive_sequencer
  import jk_drive_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tgt_valid,
  input  logic [WIDTH-1:0]                 tgt_data,
  input  logic                             tgt_mode,
  output logic                             tgt_ready,
  input  logic [WIDTH-1:0]                 q_fb,
  output logic [WIDTH-1:0]                 j,
  output logic [WIDTH-1:0]                 k,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [cnt_width(MAX_RETRY)-1:0]  retry_cnt
);

  localparam int CNT_W = cnt_width(MAX_RETRY);
  localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             r_state;
  logic [WIDTH-1:0]   r_tgt;
  logic               r_mode;
  logic [CNT_W-1:0]   r_retry_cnt;
  logic               r_done;
  logic               r_err;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_retry_inc;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_match;
  logic               w_drive;
  logic [WIDTH-1:0]   w_j_raw;
  logic [WIDTH-1:0]   w_k_raw;

  assign w_match = (q_fb == r_tgt);
  assign w_drive = (r_state == DRIVE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retry_inc = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        // tgt_ready is exactly (state == IDLE), so valid alone is the handshake.
        if (tgt_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = DRIVE;
        end
      end

      DRIVE: begin
        // The bank captures the excitation at the end of this single cycle.
        w_state_nxt = CHECK;
      end

      CHECK: begin
        if (w_match) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_retry_cnt < RETRY_LIMIT) begin
          w_retry_inc = 1'b1;
          w_state_nxt = DRIVE;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Target latch, retry counter and registered status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt       <= '0;
      r_mode      <= MODE_TOGGLE;
      r_retry_cnt <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Data is captured only on the accept edge; later changes on the
      // request bus while busy have no effect.
      if (w_accept) begin
        r_tgt       <= tgt_data;
        r_mode      <= tgt_mode;
        r_retry_cnt <= '0;
      end else if (w_retry_inc) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end
      // Mutually exclusive by construction of the CHECK decode.
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit excitation
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < WIDTH; g++) begin : g_excite
    jk_excite u_excite (
      .i_q    (q_fb[g]),
      .i_tgt  (r_tgt[g]),
      .i_mode (r_mode),
      .o_j    (w_j_raw[g]),
      .o_k    (w_k_raw[g])
    );
  end

  // Gating by the state register means an asynchronous reset removes the
  // excitation immediately, so the bank never sees a partial drive.
  assign j = w_j_raw & {WIDTH{w_drive}};
  assign k = w_k_raw & {WIDTH{w_drive}};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tgt_ready = (r_state == IDLE);
  assign busy      = (r_state == DRIVE) || (r_state == CHECK);
  assign done      = r_done;
  assign err       = r_err;
  assign retry_cnt = r_retry_cnt;

endmodule : jk_drive_sequencer

// File: tb/tb_jk_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_drive_sequencer
// Self-checking bench for jk_drive_sequencer with a behavioural JK bank.
// -----------------------------------------------------------------------------
module tb_jk_drive_sequencer;

  localparam int W  = 8;
  localparam int MR = 3;

  logic         clk;
  logic         rst_n;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         tgt_mode;
  logic         tgt_ready;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   retry_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural JK bank with optional stuck-at-0 bits and a preload port.
  logic [W-1:0] bank_q;
  logic [W-1:0] stuck;
  logic         bank_ld;
  logic [W-1:0] bank_ld_val;

  assign q_fb = bank_q;

  jk_drive_sequencer #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_mode  (tgt_mode),
    .tgt_ready (tgt_ready),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                           input logic [W-1:0] jj,
                                           input logic [W-1:0] kk);
    logic [W-1:0] n;
    for (int b = 0; b < W; b++) begin
      case ({jj[b], kk[b]})
        2'b00:   n[b] = q[b];
        2'b01:   n[b] = 1'b0;
        2'b10:   n[b] = 1'b1;
        default: n[b] = ~q[b];
      endcase
    end
    return n;
  endfunction

  // Stuck bits are pulled to 0 only when they are actually excited.
  always @(posedge clk) begin
    if (bank_ld) bank_q <= bank_ld_val;
    else         bank_q <= jk_next(bank_q, j, k) & ~(stuck & (j | k));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    @(negedge clk);
    bank_ld = 1'b1;
    bank_ld_val = v;
    @(negedge clk);
    bank_ld = 1'b0;
  endtask

  // One transaction from offer to done/err; returns what was observed.
  task automatic run_txn(input logic mode, input logic [W-1:0] tgt, input logic once,
                         output logic [W-1:0] j1, output logic [W-1:0] k1,
                         output int lat, output logic gdone, output logic gerr,
                         output logic [1:0] gretry, output logic [W-1:0] gq,
                         output int drives);
    int busy_n;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    tgt_mode  = mode;
    chk("ready_before_accept", 32'(tgt_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request bus: only the accept-edge values may matter.
    tgt_valid = 1'b0;
    tgt_data  = ~tgt;
    tgt_mode  = ~mode;
    j1 = j;
    k1 = k;
    lat = 0;
    busy_n = 0;
    while (!(done || err) && lat < 40) begin
      if (busy) busy_n++;
      if (once && lat == 1) stuck = '0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) begin
      errors++;
      $display("FAIL txn_timeout: no done/err within 40 cycles");
    end
    gdone  = done;
    gerr   = err;
    gretry = retry_cnt;
    gq     = q_fb;
    drives = busy_n / 2;
    chk("done_err_exclusive", 32'(done && err), 32'd0);
  endtask

  typedef struct {
    logic         mode;
    logic [W-1:0] q0;
    logic [W-1:0] tgt;
    logic [W-1:0] stk;
    logic         once;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    int           elat;
    logic         edone;
    int           eretry;
    logic [W-1:0] eq;
    int           edrv;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [W-1:0] oj, ok, oq;
    int           olat, odrv;
    logic         od, oe;
    logic [1:0]   orc;

    tbl[0] = '{1'b0, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5, 2, 1'b1, 0, 8'hA5, 1};
    tbl[1] = '{1'b1, 8'h0F, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'hC3, 2, 1'b1, 0, 8'h3C, 1};
    tbl[2] = '{1'b0, 8'h5A, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 2, 1'b1, 0, 8'h5A, 1};
    tbl[3] = '{1'b0, 8'h00, 8'h04, 8'h04, 1'b0, 8'h04, 8'h04, 8, 1'b0, 3, 8'h00, 4};
    tbl[4] = '{1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 8'h01, 8'h01, 4, 1'b1, 1, 8'h01, 2};

    rst_n = 1'b0;
    tgt_valid = 1'b0;
    tgt_data = '0;
    tgt_mode = 1'b0;
    stuck = '0;
    bank_ld = 1'b1;
    bank_ld_val = '0;

    // Reset state, with an offer present that must not be taken.
    #3;
    chk("rst_ready", 32'(tgt_ready), 32'd1);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    tgt_valid = 1'b1;
    tgt_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_accept_busy", 32'(busy), 32'd0);
    chk("rst_no_accept_j", 32'(j), 32'd0);
    @(negedge clk);
    tgt_valid = 1'b0;
    bank_ld = 1'b0;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      load_bank(tbl[i].q0);
      stuck = tbl[i].stk;
      run_txn(tbl[i].mode, tbl[i].tgt, tbl[i].once, oj, ok, olat, od, oe, orc, oq, odrv);
      chk($sformatf("v%0d_j", i), 32'(oj), 32'(tbl[i].ej));
      chk($sformatf("v%0d_k", i), 32'(ok), 32'(tbl[i].ek));
      chk($sformatf("v%0d_latency", i), 32'(olat), 32'(tbl[i].elat));
      chk($sformatf("v%0d_done", i), 32'(od), 32'(tbl[i].edone));
      chk($sformatf("v%0d_err", i), 32'(oe), 32'(!tbl[i].edone));
      chk($sformatf("v%0d_retry", i), 32'(orc), 32'(tbl[i].eretry));
      chk($sformatf("v%0d_q", i), 32'(oq), 32'(tbl[i].eq));
      chk($sformatf("v%0d_drives", i), 32'(odrv), 32'(tbl[i].edrv));
      if (!tbl[i].edone) begin
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("v%0d_retry_hold", i), 32'(retry_cnt), 32'(tbl[i].eretry));
        chk($sformatf("v%0d_err_pulse", i), 32'(err), 32'd0);
      end
      stuck = '0;
    end

    // Asynchronous reset in the middle of a DRIVE cycle
    load_bank(8'h00);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = 8'hFF;
    tgt_mode  = 1'b1;
    @(posedge clk);
    #2;
    tgt_valid = 1'b0;
    chk("mid_drive_j", 32'(j), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("arst_j", 32'(j), 32'd0);
    chk("arst_k", 32'(k), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(tgt_ready), 32'd1);
    chk("arst_retry", 32'(retry_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_bank_hold", 32'(q_fb), 32'h00);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 8'hFF, 1'b0, oj, ok, olat, od, oe, orc, oq, odrv);
    chk("post_rst_j", 32'(oj), 32'hFF);
    chk("post_rst_k", 32'(ok), 32'h00);
    chk("post_rst_latency", 32'(olat), 32'd2);
    chk("post_rst_done", 32'(od), 32'd1);
    chk("post_rst_q", 32'(oq), 32'hFF);

    // Randomized transactions against a rule-level model:
    // every attempt leaves Q = target with stuck bits cleared, so the
    // transaction succeeds on the first try unless a stuck bit must be 1.
    for (int n = 0; n < 40; n++) begin
      logic         rm;
      logic [W-1:0] rq0, rt, rs, xj, xk, xq;
      logic         xdone;
      int           xlat, xret, xdrv;
      rm  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      rq0 = 8'($urandom) & ~rs;
      rt  = 8'($urandom);
      xj  = rm ? rt  : (rq0 ^ rt);
      xk  = rm ? ~rt : (rq0 ^ rt);
      xdone = ((rt & rs) == 8'h00);
      xlat  = xdone ? 2 : 2 * (MR + 1);
      xret  = xdone ? 0 : MR;
      xdrv  = xdone ? 1 : MR + 1;
      xq    = rt & ~rs;
      load_bank(rq0);
      stuck = rs;
      run_txn(rm, rt, 1'b0, oj, ok, olat, od, oe, orc, oq, odrv);
      chk($sformatf("r%0d_j", n), 32'(oj), 32'(xj));
      chk($sformatf("r%0d_k", n), 32'(ok), 32'(xk));
      chk($sformatf("r%0d_latency", n), 32'(olat), 32'(xlat));
      chk($sformatf("r%0d_done", n), 32'(od), 32'(xdone));
      chk($sformatf("r%0d_retry", n), 32'(orc), 32'(xret));
      chk($sformatf("r%0d_q", n), 32'(oq), 32'(xq));
      chk($sformatf("r%0d_drives", n), 32'(odrv), 32'(xdrv));
      stuck = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_jk_drive_sequencer

// File: doc/jk_drive_sequencer.md
# jk_drive_sequencer

Drives the J/K inputs of an external bank of WIDTH JK flip-flops so that the bank's Q word reaches a requested target value. It reads the bank's Q outputs back, verifies the result, and retries a bounded number of times. It is the controlling side of the JK flip-flop interface: the flip-flop turns J/K into Q, and this block turns a desired Q into J/K. It sits between a register-update requester (valid/ready) and the JK bank.

## Interface
- WIDTH, 8: number of JK flip-flops driven.
- MAX_RETRY, 3: re-drive attempts allowed after the first failed check.
- clk  in  1: single clock, rising edge. The JK bank uses the same clock.
- rst_n  in  1: asynchronous, active-low reset.
- tgt_valid  in  1: a target word is offered.
- tgt_data  in  WIDTH: target Q word.
- tgt_mode  in  1: 0 = TOGGLE (feedback-based), 1 = FORCE (set/reset).
- tgt_ready  out  1: block can accept a target; equals (state == IDLE).
- q_fb  in  WIDTH: Q outputs of the JK bank.
- j  out  WIDTH: J drive to the bank.
- k  out  WIDTH: K drive to the bank.
- busy  out  1: high in DRIVE and CHECK.
- done  out  1: one-cycle pulse when the target is reached.
- err  out  1: one-cycle pulse when retries are exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1): re-drives used by the current or last transaction.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1 and j=k=0.
  - On tgt_valid && tgt_ready at a clock edge: latch tgt_data and tgt_mode, clear retry_cnt, go to DRIVE.
- DRIVE (exactly one cycle): j and k are combinational from the latched target, the latched mode and the current q_fb.
  - TOGGLE, per bit: if q_fb==target, j=0,k=0 (hold); else j=1,k=1 (toggle).
  - FORCE, per bit: if target=1, j=1,k=0; else j=0,k=1. This ignores q_fb.
  - The bank updates at the end of this cycle. Next state is always CHECK.
- CHECK (one cycle): j=k=0. Compare q_fb against the latched target.
  - Match: done=1 in the following cycle; go to IDLE.
  - Mismatch and retry_cnt < MAX_RETRY: retry_cnt+1; go to DRIVE.
  - Mismatch and retry_cnt == MAX_RETRY: err=1 in the following cycle; go to IDLE.
- done and err are registered and never high together.
- retry_cnt holds its value in IDLE until the next accept.
- tgt_valid while busy is ignored. The requester must hold its offer until tgt_ready.
- Changing tgt_data while tgt_ready=0 has no effect. Data is latched only at the accept edge.

## Timing
- Reset (asynchronous, rst_n low):
  - state=IDLE, j=0, k=0, busy=0, done=0, err=0, retry_cnt=0, latched target=0, latched mode=0.
  - tgt_ready reads 1, but no transfer is accepted while rst_n=0.
- Reset asserted mid-DRIVE: j/k drop to 0 immediately, asynchronously. The bank sees no partial excitation at the next edge.
- Success latency: accept at edge N → DRIVE during N..N+1 → CHECK during N+1..N+2 → done high during N+2..N+3 with tgt_ready=1. Back-to-back accept is possible at edge N+3.
- Each retry adds 2 cycles. Worst case until err is 2·(MAX_RETRY+1) cycles after accept.
- q_fb must reflect the bank's registered Q with no added delay. The bank's Q must be valid in the cycle after its clock edge.

## Structure
- Package jk_drive_pkg holds:
  - state enum (IDLE, DRIVE, CHECK);
  - mode constants MODE_TOGGLE=1'b0, MODE_FORCE=1'b1;
  - J/K pair constants HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11.
- Sub-module jk_excite: a per-bit combinational map from (q, target, mode) to (j, k). The top instantiates it WIDTH times with a generate loop and gates its outputs with (state == DRIVE).
- The bench carries a behavioural JK bank model: hold, reset, set and toggle on the rising edge, matching the team's JK flip-flop.

## Test plan
- Reset, then TOGGLE, WIDTH=8, bank Q=0x00, target 0xA5.
  - Required: j=k=0xA5 for one cycle; done pulses 2 cycles after accept; q_fb=0xA5; retry_cnt=0.
- FORCE with bank Q=0x0F, target 0x3C.
  - Required: j=0x3C and k=0xC3 in DRIVE; done pulses; q_fb=0x3C.
- TOGGLE with target equal to the current Q (0x5A).
  - Required: j=k=0x00 in DRIVE; done pulses; Q stays 0x5A.
- Bank model with bit 2 stuck at 0, target 0x04, MAX_RETRY=3.
  - Required: 4 DRIVE cycles; retry_cnt=3; err pulses 8 cycles after accept; done never asserts.
- Bit 0 stuck for only the first attempt, target 0x01.
  - Required: one retry; retry_cnt=1; done pulses 4 cycles after accept.
- rst_n low during DRIVE (asynchronous, mid-cycle).
  - Required: j=k=0 immediately; bank Q unchanged at the next edge; all outputs at reset values.
  - After release, tgt_valid with 0xFF (FORCE) completes normally.
